// File: rtl/slurm16_port_responder_pkg.sv
// Shared definitions for the slurm16 CPU port responder: FSM state encoding,
// access opcodes and the data pattern returned by a timed-out read.
package cpu_port_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } port_state_t;

  typedef enum logic {
    PORT_OP_RD = 1'b0,
    PORT_OP_WR = 1'b1
  } port_op_t;

  // Replicated to the data width: a timed-out read returns all ones.
  localparam logic TIMEOUT_RDATA_BIT = 1'b1;

endpackage

// File: rtl/slurm16_port_responder_if.sv
// Port bus between the execute stage, the responder and the peripheral slots.
// The slave modport is the responder; the master modport is its environment.
interface slurm16_port_responder_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int SLOT_BITS    = 2
);
  localparam int SLOTS = 1 << SLOT_BITS;

  logic [ADDRESS_BITS-1:0] port_address;
  logic [BITS-1:0]         port_out;
  logic                    port_rd;
  logic                    port_wr;
  logic [BITS-1:0]         port_in;
  logic                    port_in_valid;
  logic                    port_stall;
  logic [SLOTS-1:0]        per_sel;
  logic [ADDRESS_BITS-1:0] per_addr;
  logic [BITS-1:0]         per_wdata;
  logic                    per_rd;
  logic                    per_wr;
  logic [SLOTS*BITS-1:0]   per_rdata;
  logic [SLOTS-1:0]        per_ready;
  logic                    timeout_err;

  modport slave (
    input  port_address, port_out, port_rd, port_wr, per_rdata, per_ready,
    output port_in, port_in_valid, port_stall, per_sel, per_addr, per_wdata,
           per_rd, per_wr, timeout_err
  );

  modport master (
    output port_address, port_out, port_rd, port_wr, per_rdata, per_ready,
    input  port_in, port_in_valid, port_stall, per_sel, per_addr, per_wdata,
           per_rd, per_wr, timeout_err
  );

endinterface

// File: rtl/slurm16_port_slot_mux.sv
// Combinational slot decoder: one-hot select for the latched slot plus the
// matching read-data and ready lines picked out of the per-slot buses.
module slurm16_port_slot_mux #(
  parameter int BITS      = 16,
  parameter int SLOT_BITS = 2
) (
  input  logic [SLOT_BITS-1:0]              i_slot,
  input  logic [(1<<SLOT_BITS)*BITS-1:0]    i_per_rdata,
  input  logic [(1<<SLOT_BITS)-1:0]         i_per_ready,
  output logic [(1<<SLOT_BITS)-1:0]         o_sel,
  output logic [BITS-1:0]                   o_rdata,
  output logic                              o_ready
);
  localparam int SLOTS = 1 << SLOT_BITS;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    o_sel   = '0;
    o_rdata = '0;
    o_ready = 1'b0;
    for (int n = 0; n < SLOTS; n++) begin
      if (i_slot == SLOT_BITS'(n)) begin
        o_sel[n] = 1'b1;
        o_rdata  = i_per_rdata[n*BITS +: BITS];
        o_ready  = i_per_ready[n];
      end
    end
  end

endmodule

// File: rtl/slurm16_port_responder.sv
// CPU port responder: decodes peek/poke requests to a peripheral slot, holds
// the strobe until that slot is ready and stalls the pipeline meanwhile.
// Build option SLURM16_PORT_TIMEOUT_EN forces completion of a stuck access.
module slurm16_port_responder
  import cpu_port_defs::*;
#(
  parameter int BITS           = 16,
  parameter int ADDRESS_BITS   = 16,
  parameter int SLOT_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     CLK,
  input  logic                     RSTb,
  slurm16_port_responder_if.slave  bus
);
  localparam int SLOTS = 1 << SLOT_BITS;

  port_state_t             r_state;
  port_state_t             w_next_state;
  port_op_t                r_op;
  logic [SLOT_BITS-1:0]    r_slot;
  logic [ADDRESS_BITS-1:0] r_addr;
  logic [BITS-1:0]         r_wdata;
  logic [BITS-1:0]         r_port_in;

  logic                    w_req;
  logic                    w_accept;
  logic [SLOTS-1:0]        w_sel;
  logic [BITS-1:0]         w_slot_rdata;
  logic                    w_slot_ready;
  logic                    w_timeout;

  assign w_req    = bus.port_rd | bus.port_wr;
  assign w_accept = (r_state == IDLE) && w_req;

  slurm16_port_slot_mux #(
    .BITS      (BITS),
    .SLOT_BITS (SLOT_BITS)
  ) u_slot_mux (
    .i_slot      (r_slot),
    .i_per_rdata (bus.per_rdata),
    .i_per_ready (bus.per_ready),
    .o_sel       (w_sel),
    .o_rdata     (w_slot_rdata),
    .o_ready     (w_slot_ready)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RSTb) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next_state = ACCESS;
      ACCESS:  if (w_slot_ready || w_timeout) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.port_stall    = w_accept || (r_state == ACCESS);
    bus.per_sel       = (r_state == ACCESS) ? w_sel : '0;
    bus.per_rd        = (r_state == ACCESS) && (r_op == PORT_OP_RD);
    bus.per_wr        = (r_state == ACCESS) && (r_op == PORT_OP_WR);
    bus.port_in_valid = (r_state == DONE) && (r_op == PORT_OP_RD);
  end

  assign bus.per_addr  = r_addr;
  assign bus.per_wdata = r_wdata;
  assign bus.port_in   = r_port_in;

  // Request latch; write wins when both strobes arrive together.
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      r_op      <= PORT_OP_RD;
      r_slot    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_port_in <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= bus.port_wr ? PORT_OP_WR : PORT_OP_RD;
        r_slot  <= bus.port_address[ADDRESS_BITS-1 -: SLOT_BITS];
        r_addr  <= bus.port_address;
        r_wdata <= bus.port_out;
      end
      if ((r_state == ACCESS) && (r_op == PORT_OP_RD)) begin
        if (w_slot_ready)   r_port_in <= w_slot_rdata;
        else if (w_timeout) r_port_in <= {BITS{TIMEOUT_RDATA_BIT}};
      end
    end
  end

`ifdef SLURM16_PORT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout_err;

  // The counter idles at zero outside ACCESS, so it is clear on entry.
  assign w_timeout = (r_state == ACCESS) && !w_slot_ready &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RSTb) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state != ACCESS)  r_cnt <= '0;
      else if (!w_slot_ready) r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_timeout       = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_slurm16_port_responder.sv
// Directed bench for slurm16_port_responder: reads, writes, dual strobes,
// reset mid-access, back-to-back requests and the stuck-access behaviour.
module tb_slurm16_port_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  logic prev_strobe = 1'b0;

  always #5 clk = ~clk;

  slurm16_port_responder_if #(.BITS(16), .ADDRESS_BITS(16), .SLOT_BITS(2)) bus ();

  slurm16_port_responder #(
    .BITS(16), .ADDRESS_BITS(16), .SLOT_BITS(2), .TIMEOUT_CYCLES(15)
  ) dut (
    .CLK  (clk),
    .RSTb (rst),
    .bus  (bus)
  );

  // Counts distinct peripheral accesses (rising edges of either strobe).
  always @(negedge clk) begin
    if ((bus.per_rd | bus.per_wr) && !prev_strobe) n_acc++;
    prev_strobe = bus.per_rd | bus.per_wr;
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.port_address = '0; bus.port_out = '0;
    bus.port_rd = 1'b0; bus.port_wr = 1'b0;
    bus.per_ready = '0;
    bus.per_rdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
    tick(); tick(); #2;
    n_vec++;
    if ({bus.port_in, bus.port_in_valid, bus.port_stall, bus.per_sel, bus.per_rd, bus.per_wr} !== 24'h0) begin
      n_err++; $display("FAIL reset_outputs in=%h vld=%b stall=%b sel=%b rd=%b wr=%b", bus.port_in, bus.port_in_valid, bus.port_stall, bus.per_sel, bus.per_rd, bus.per_wr);
    end
    n_vec++;
    if ({bus.per_addr, bus.per_wdata, bus.timeout_err} !== 33'h0) begin
      n_err++; $display("FAIL reset_latches addr=%h wdata=%h terr=%b, expected all 0", bus.per_addr, bus.per_wdata, bus.timeout_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_slot1();
    tick(); bus.port_address = 16'h4010; bus.port_rd = 1'b1; #2;
    n_vec++;
    if ({bus.port_stall, bus.per_rd, bus.per_sel} !== 6'b1_0_0000) begin
      n_err++; $display("FAIL rd1_c0 stall=%b rd=%b sel=%b expected 1 0 0000", bus.port_stall, bus.per_rd, bus.per_sel);
    end
    tick(); bus.per_ready = 4'b0010; #2;
    n_vec++;
    if ({bus.per_sel, bus.per_rd, bus.per_wr, bus.port_stall, bus.port_in_valid} !== 8'b0010_1_0_1_0) begin
      n_err++; $display("FAIL rd1_c1 sel=%b rd=%b wr=%b stall=%b vld=%b expected 0010 1 0 1 0", bus.per_sel, bus.per_rd, bus.per_wr, bus.port_stall, bus.port_in_valid);
    end
    n_vec++;
    if (bus.per_addr !== 16'h4010) begin
      n_err++; $display("FAIL rd1_addr got %h expected 4010", bus.per_addr);
    end
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_in, bus.port_in_valid, bus.port_stall, bus.per_sel, bus.per_rd} !== {16'hBEEF, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
      n_err++; $display("FAIL rd1_done in=%h vld=%b stall=%b sel=%b rd=%b expected BEEF 1 0 0000 0", bus.port_in, bus.port_in_valid, bus.port_stall, bus.per_sel, bus.per_rd);
    end
    tick(); bus.port_rd = 1'b0; #2;
    n_vec++;
    if ({bus.port_in, bus.port_in_valid, bus.port_stall} !== {16'hBEEF, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL rd1_after in=%h vld=%b stall=%b expected BEEF 0 0", bus.port_in, bus.port_in_valid, bus.port_stall);
    end
  endtask

  // Other slots raise ready during the wait; only slot 3's ready may end it.
  task automatic test_write_slot3();
    tick(); bus.port_address = 16'hC002; bus.port_out = 16'h1234; bus.port_wr = 1'b1; #2;
    n_vec++;
    if (bus.port_stall !== 1'b1) begin
      n_err++; $display("FAIL wr3_c0_stall got %b expected 1", bus.port_stall);
    end
    for (int c = 1; c <= 4; c++) begin
      tick(); bus.per_ready = (c == 4) ? 4'b1000 : 4'b0111; #2;
      n_vec++;
      if ({bus.per_wr, bus.per_rd, bus.per_sel, bus.per_wdata, bus.port_stall, bus.port_in_valid} !== {1'b1, 1'b0, 4'b1000, 16'h1234, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL wr3_c%0d wr=%b rd=%b sel=%b wdata=%h stall=%b vld=%b expected 1 0 1000 1234 1 0", c, bus.per_wr, bus.per_rd, bus.per_sel, bus.per_wdata, bus.port_stall, bus.port_in_valid);
      end
    end
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_stall, bus.port_in_valid, bus.per_wr, bus.per_sel, bus.port_in} !== {1'b0, 1'b0, 1'b0, 4'b0000, 16'hBEEF}) begin
      n_err++; $display("FAIL wr3_done stall=%b vld=%b wr=%b sel=%b in=%h expected 0 0 0 0000 BEEF", bus.port_stall, bus.port_in_valid, bus.per_wr, bus.per_sel, bus.port_in);
    end
    tick(); bus.port_wr = 1'b0;
  endtask

  task automatic test_rd_wr_both();
    tick(); bus.port_address = 16'h8004; bus.port_out = 16'hABCD; bus.port_rd = 1'b1; bus.port_wr = 1'b1;
    tick(); bus.per_ready = 4'b0100; #2;
    n_vec++;
    if ({bus.per_wr, bus.per_rd, bus.per_sel, bus.per_wdata} !== {1'b1, 1'b0, 4'b0100, 16'hABCD}) begin
      n_err++; $display("FAIL both_access wr=%b rd=%b sel=%b wdata=%h expected 1 0 0100 ABCD", bus.per_wr, bus.per_rd, bus.per_sel, bus.per_wdata);
    end
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_in_valid, bus.per_rd, bus.port_in} !== {1'b0, 1'b0, 16'hBEEF}) begin
      n_err++; $display("FAIL both_done vld=%b rd=%b in=%h expected 0 0 BEEF", bus.port_in_valid, bus.per_rd, bus.port_in);
    end
    tick(); bus.port_rd = 1'b0; bus.port_wr = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    tick(); bus.port_address = 16'h0008; bus.port_rd = 1'b1;
    tick(); #2;
    n_vec++;
    if ({bus.per_rd, bus.per_sel} !== 5'b1_0001) begin
      n_err++; $display("FAIL rst_mid_c1 rd=%b sel=%b expected 1 0001", bus.per_rd, bus.per_sel);
    end
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; bus.port_rd = 1'b0; #2;
    n_vec++;
    if ({bus.per_sel, bus.per_rd, bus.per_wr, bus.port_in_valid, bus.port_stall, bus.port_in} !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      n_err++; $display("FAIL rst_mid_abort sel=%b rd=%b wr=%b vld=%b stall=%b in=%h expected 0000 0 0 0 0 0000", bus.per_sel, bus.per_rd, bus.per_wr, bus.port_in_valid, bus.port_stall, bus.port_in);
    end
    tick(); #2;
    n_vec++;
    if (bus.port_in_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_late_valid got %b expected 0", bus.port_in_valid);
    end
    tick(); bus.port_address = 16'h0008; bus.port_rd = 1'b1;
    tick(); bus.per_ready = 4'b0001; #2;
    n_vec++;
    if ({bus.per_rd, bus.per_sel} !== 5'b1_0001) begin
      n_err++; $display("FAIL rst_mid_retry_sel rd=%b sel=%b expected 1 0001", bus.per_rd, bus.per_sel);
    end
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_in_valid, bus.port_in} !== {1'b1, 16'h1111}) begin
      n_err++; $display("FAIL rst_mid_retry_data vld=%b in=%h expected 1 1111", bus.port_in_valid, bus.port_in);
    end
    tick(); bus.port_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_acc;
    tick(); bus.port_address = 16'h4020; bus.port_rd = 1'b1;
    tick(); bus.per_ready = 4'b0010;
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_stall, bus.port_in_valid, bus.port_in} !== {1'b0, 1'b1, 16'hBEEF}) begin
      n_err++; $display("FAIL b2b_done1 stall=%b vld=%b in=%h expected 0 1 BEEF", bus.port_stall, bus.port_in_valid, bus.port_in);
    end
    tick(); bus.port_rd = 1'b0; bus.port_wr = 1'b1; bus.port_address = 16'h0030; bus.port_out = 16'h5555; #2;
    n_vec++;
    if ({bus.port_stall, bus.per_sel} !== 5'b1_0000) begin
      n_err++; $display("FAIL b2b_accept2 stall=%b sel=%b expected 1 0000", bus.port_stall, bus.per_sel);
    end
    tick(); bus.per_ready = 4'b0001; #2;
    n_vec++;
    if ({bus.per_wr, bus.per_sel, bus.per_wdata, bus.per_addr} !== {1'b1, 4'b0001, 16'h5555, 16'h0030}) begin
      n_err++; $display("FAIL b2b_access2 wr=%b sel=%b wdata=%h addr=%h expected 1 0001 5555 0030", bus.per_wr, bus.per_sel, bus.per_wdata, bus.per_addr);
    end
    tick(); bus.per_ready = '0; #2;
    n_vec++;
    if ({bus.port_stall, bus.port_in_valid} !== 2'b00) begin
      n_err++; $display("FAIL b2b_done2 stall=%b vld=%b expected 0 0", bus.port_stall, bus.port_in_valid);
    end
    tick(); bus.port_wr = 1'b0;
    tick(); #2;
    n_vec++;
    if (n_acc - base !== 2) begin
      n_err++; $display("FAIL b2b_access_count got %0d expected 2", n_acc - base);
    end
  endtask

  task automatic test_stuck_access();
    int cycles;
    bool_done: begin end
    tick(); bus.port_address = 16'h4000; bus.port_rd = 1'b1; bus.per_ready = '0;
`ifdef SLURM16_PORT_TIMEOUT_EN
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      tick(); #2;
      if (!bus.port_stall) break;
      cycles++;
    end
    n_vec++;
    if (cycles !== 15) begin
      n_err++; $display("FAIL timeout_cycles got %0d access cycles expected 15", cycles);
    end
    n_vec++;
    if ({bus.port_in_valid, bus.port_in, bus.timeout_err} !== {1'b1, 16'hFFFF, 1'b1}) begin
      n_err++; $display("FAIL timeout_done vld=%b in=%h terr=%b expected 1 FFFF 1", bus.port_in_valid, bus.port_in, bus.timeout_err);
    end
    tick(); bus.port_rd = 1'b0;
    repeat (3) tick();
    #2;
    n_vec++;
    if (bus.timeout_err !== 1'b1) begin
      n_err++; $display("FAIL timeout_sticky got %b expected 1", bus.timeout_err);
    end
`else
    cycles = 0;
    repeat (100) tick();
    #2;
    n_vec++;
    if ({bus.port_stall, bus.per_rd, bus.timeout_err} !== 3'b110) begin
      n_err++; $display("FAIL stuck_wait stall=%b rd=%b terr=%b expected 1 1 0", bus.port_stall, bus.per_rd, bus.timeout_err);
    end
    tick(); rst = 1'b1; bus.port_rd = 1'b0;
    tick(); rst = 1'b0; #2;
    n_vec++;
    if ({bus.port_stall, bus.per_rd, bus.port_in_valid} !== 3'b000) begin
      n_err++; $display("FAIL stuck_reset stall=%b rd=%b vld=%b expected 0 0 0", bus.port_stall, bus.per_rd, bus.port_in_valid);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read_slot1();
    test_write_slot3();
    test_rd_wr_both();
    test_reset_mid_access();
    test_back_to_back();
    test_stuck_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slurm16_port_responder.md
Name: slurm16_port_responder

Overview:
- Responder end of the CPU port (peek/poke) bus: accepts the execute stage's port_rd / port_wr request and decodes it to one of 2^SLOT_BITS peripheral slots.
- Sequences a ready-handshaked access to the selected slot and stalls the pipeline until the access completes.
- Returns read data to the writeback path.
- Sits between the CPU execute stage and the peripheral blocks (GPIO, UART, timers, ...).

Parameters:
- BITS, 16, data width.
- ADDRESS_BITS, 16, port address width.
- SLOT_BITS, 2, number of slot-select bits: slot = port_address[ADDRESS_BITS-1 -: SLOT_BITS].
- TIMEOUT_CYCLES, 15, max ACCESS cycles before forced completion (used only with PORT_TIMEOUT_EN).

Ports:
- CLK  input  1  clock.
- RSTb  input  1  reset; synchronous, active-high (asserted = 1).
- port_address  input  ADDRESS_BITS  request address from execute stage.
- port_out  input  BITS  write data from execute stage.
- port_rd  input  1  read request.
- port_wr  input  1  write request.
- port_in  output  BITS  read data to writeback.
- port_in_valid  output  1  one-cycle pulse: port_in valid (reads only).
- port_stall  output  1  hold pipeline.
- per_sel  output  2^SLOT_BITS  one-hot slot select.
- per_addr  output  ADDRESS_BITS  latched address.
- per_wdata  output  BITS  latched write data.
- per_rd  output  1  read strobe.
- per_wr  output  1  write strobe.
- per_rdata  input  2^SLOT_BITS*BITS  concatenated slot read data; slot n at [n*BITS +: BITS].
- per_ready  input  2^SLOT_BITS  per-slot completion.
- timeout_err  output  1  sticky timeout flag (feature only; tied 0 otherwise).

Behaviour:
- Reset (RSTb=1 at edge):
  - state=IDLE.
  - All outputs 0: port_in, port_in_valid, per_sel, per_addr, per_wdata, per_rd, per_wr, timeout_err.
  - port_stall=0 only while no request is presented (see IDLE).
  - Reset mid-access abandons the access: strobes and selects drop at that edge, and no port_in_valid is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If port_rd|port_wr: port_stall=1 combinationally in the same cycle.
  - Latch address, write data, op, and slot. Next state ACCESS.
  - If both port_rd and port_wr are set, write wins and the read is ignored.
- ACCESS:
  - per_sel[slot]=1 and per_rd or per_wr=1; per_addr / per_wdata hold latched values; port_stall=1.
  - When per_ready[slot]=1 (other slots' ready ignored): on a read, latch per_rdata of that slot into port_in. Next state DONE.
  - Strobes are held until ready; they are not single-cycle pulses.
- DONE:
  - per_sel / per_rd / per_wr=0 and port_stall=0.
  - port_in_valid=1 for this cycle if the access was a read.
  - Inputs seen in DONE are ignored, because the execute stage still presents the same request. Next state IDLE.
- port_in holds its value until the next completed read.
- Latency: request in cycle 0; ACCESS starts cycle 1. A ready in cycle k gives DONE in cycle k+1.
  - Minimum request-to-port_in_valid is 2 cycles.
  - Minimum stall is 2 cycles (0 and 1).
- Back-to-back requests: a new request is accepted only in IDLE, so the minimum spacing is 3 cycles.
- Slot decode uses the upper bits only; the full address is passed to the peripheral.
- A write completion pulses nothing externally; stall release is the only indication.

Optional Feature:
- Macro: SLURM16_PORT_TIMEOUT_EN.
- Defined:
  - A 16-bit-safe counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES, force DONE. A read returns {BITS{1'b1}}.
  - timeout_err is set and stays set until reset.
- Undefined: ACCESS waits for ready indefinitely; timeout_err is tied to 0; no counter is present.

Decomposition:
- Shared package cpu_port_defs: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), PORT_OP_RD / PORT_OP_WR constants, timeout read-data constant.
- One sub-module: slurm16_port_slot_mux, a combinational slot decoder (one-hot sel) plus rdata/ready mux.
- FSM and latches stay in the top.

Test Plan:
- Read slot 1 (port_address=16'h4010), per_ready[1] high in the first ACCESS cycle, per_rdata slot1=16'hBEEF → per_sel=4'b0010 and per_rd in cycle 1; port_in=16'hBEEF with port_in_valid in cycle 2; port_stall high in cycles 0–1 only.
- Write 16'h1234 to 16'hC002 (slot 3), ready delayed 3 cycles → per_wr, per_wdata=16'h1234 and per_sel=4'b1000 held for 4 cycles; no port_in_valid; stall released in the DONE cycle.
- port_rd and port_wr asserted together → write access only; per_rd never asserts.
- Reset asserted in the second ACCESS cycle → per_sel, per_rd and per_wr are 0 after that edge; no port_in_valid; a new request afterwards completes normally.
- Request held through DONE, then a second request → only 2 accesses total for 2 distinct requests; DONE-cycle input is ignored.
- With SLURM16_PORT_TIMEOUT_EN, ready never asserted → DONE after 15 ACCESS cycles, port_in=16'hFFFF, timeout_err=1 persisting. Without the macro, stall is still high after 100 cycles.
